// File: rtl/hdmi_clk_pkg.sv
// hdmi_clk_pkg: shared types and constants for the HDMI clock source controller.
//   state_e   - controller FSM states
//   SEL_*     - BUFGMUX select encodings (I0 = HDMI, I1 = local)
package hdmi_clk_pkg;

  localparam int unsigned EDGE_W  = 16;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    BOOT   = 3'd0,
    LOCAL  = 3'd1,
    PRE_H  = 3'd2,
    POST_H = 3'd3,
    HDMI   = 3'd4,
    PRE_L  = 3'd5,
    POST_L = 3'd6
  } state_e;

  localparam logic SEL_HDMI  = 1'b0;
  localparam logic SEL_LOCAL = 1'b1;

endpackage

// File: rtl/clk_rate_window.sv
// clk_rate_window: measures tmds_div edge rate and vsync activity per window.
//   clk_i       - clk75
//   rst_i       - async active-high reset
//   tmds_div_i  - async divided TMDS toggle
//   vsync_i     - async HDMI vsync
//   win_done_o  - 1-cycle pulse after each window closes
//   win_good_o  - last window's edge count was within [MIN_EDGES, MAX_EDGES]
//   vs_seen_o   - a vsync rising edge arrived since the last win_done
//   edge_cnt_o  - saturating edge count of the last completed window
module clk_rate_window
  import hdmi_clk_pkg::*;
#(
  parameter int unsigned WIN_CYC   = 65536,
  parameter int unsigned MIN_EDGES = 200,
  parameter int unsigned MAX_EDGES = 1200
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tmds_div_i,
  input  logic              vsync_i,
  output logic              win_done_o,
  output logic              win_good_o,
  output logic              vs_seen_o,
  output logic [EDGE_W-1:0] edge_cnt_o
);

  localparam int unsigned       WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [EDGE_W-1:0] ACC_MAX  = '1;
  localparam logic [EDGE_W-1:0] MIN_E    = EDGE_W'(MIN_EDGES);
  localparam logic [EDGE_W-1:0] MAX_E    = EDGE_W'(MAX_EDGES);

  // [1:0] are the synchroniser, [2] is the edge-detect history flop
  logic [2:0]        tmds_sync_q, vs_sync_q;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [EDGE_W-1:0] edge_acc_q, edge_acc_d, acc_inc;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              win_good_q, win_good_d;
  logic              win_done_q;
  logic              vs_seen_q, vs_seen_d;
  logic              tmds_rise, vs_rise, win_last;

  assign tmds_rise = tmds_sync_q[1] & ~tmds_sync_q[2];
  assign vs_rise   = vs_sync_q[1] & ~vs_sync_q[2];
  assign win_last  = (win_q == WIN_LAST);

  // Window bookkeeping; an edge on the terminal cycle lands in the closing window
  always_comb begin
    acc_inc = edge_acc_q;
    if (tmds_rise && (edge_acc_q != ACC_MAX)) acc_inc = edge_acc_q + EDGE_W'(1);
    win_d      = win_last ? '0 : win_q + WIN_W'(1);
    edge_acc_d = win_last ? '0 : acc_inc;
    edge_cnt_d = win_last ? acc_inc : edge_cnt_q;
    win_good_d = win_last ? ((acc_inc >= MIN_E) && (acc_inc <= MAX_E)) : win_good_q;
    // Cleared after the FSM samples it; a fresh edge on that cycle belongs to the new window
    vs_seen_d = vs_seen_q;
    if (win_done_q) vs_seen_d = 1'b0;
    if (vs_rise)    vs_seen_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmds_sync_q <= '0;
      vs_sync_q   <= '0;
      win_q       <= '0;
      edge_acc_q  <= '0;
      edge_cnt_q  <= '0;
      win_good_q  <= 1'b0;
      win_done_q  <= 1'b0;
      vs_seen_q   <= 1'b0;
    end else begin
      tmds_sync_q <= {tmds_sync_q[1:0], tmds_div_i};
      vs_sync_q   <= {vs_sync_q[1:0], vsync_i};
      win_q       <= win_d;
      edge_acc_q  <= edge_acc_d;
      edge_cnt_q  <= edge_cnt_d;
      win_good_q  <= win_good_d;
      win_done_q  <= win_last;
      vs_seen_q   <= vs_seen_d;
    end
  end

  assign win_done_o = win_done_q;
  assign win_good_o = win_good_q;
  assign vs_seen_o  = vs_seen_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule

// File: rtl/hdmi_clk_src_ctrl.sv
// hdmi_clk_src_ctrl: qualifies the HDMI TMDS clock and steers the BUFGMUX
// between HDMI and local clocks, holding the video pipe in reset around flips.
//   clk75       - local 75 MHz clock
//   rst         - async active-high reset
//   tmds_div    - async tmds_clk/256 toggle
//   vsync       - async HDMI vsync
//   force_local - 1 keeps or returns the mux to local
//   sel         - BUFGMUX select (0 = HDMI, 1 = local)
//   pipe_rst    - downstream video pipeline reset, active high
//   hdmi_ok     - running from HDMI
//   edge_cnt    - last window's tmds_div edge count
//   state_o     - FSM state, for debug
module hdmi_clk_src_ctrl
  import hdmi_clk_pkg::*;
#(
  parameter int unsigned WIN_CYC   = 65536,
  parameter int unsigned MIN_EDGES = 200,
  parameter int unsigned MAX_EDGES = 1200,
  parameter int unsigned QUAL_WIN  = 4,
  parameter int unsigned VS_WIN    = 2,
  parameter int unsigned GUARD_CYC = 256
) (
  input  logic               clk75,
  input  logic               rst,
  input  logic               tmds_div,
  input  logic               vsync,
  input  logic               force_local,
  output logic               sel,
  output logic               pipe_rst,
  output logic               hdmi_ok,
  output logic [EDGE_W-1:0]  edge_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned        GUARD_W    = $clog2(GUARD_CYC) + 1;
  localparam int unsigned        QUAL_W     = $clog2(QUAL_WIN) + 1;
  localparam int unsigned        VS_W       = $clog2(VS_WIN) + 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);
  localparam logic [QUAL_W-1:0]  QUAL_MAX   = QUAL_W'(QUAL_WIN);
  localparam logic [VS_W-1:0]    VS_MAX     = VS_W'(VS_WIN);

  state_e             state_q, state_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [QUAL_W-1:0]  qual_q, qual_d;
  logic [VS_W-1:0]    vs_miss_q, vs_miss_d;
  logic               sel_q, sel_d;
  logic               pipe_rst_q, pipe_rst_d;
  logic               hdmi_ok_q, hdmi_ok_d;
  logic               guard_done;
  logic               win_done, win_good, vs_seen;

  clk_rate_window #(
    .WIN_CYC  (WIN_CYC),
    .MIN_EDGES(MIN_EDGES),
    .MAX_EDGES(MAX_EDGES)
  ) u_win (
    .clk_i     (clk75),
    .rst_i     (rst),
    .tmds_div_i(tmds_div),
    .vsync_i   (vsync),
    .win_done_o(win_done),
    .win_good_o(win_good),
    .vs_seen_o (vs_seen),
    .edge_cnt_o(edge_cnt)
  );

  assign guard_done = (guard_q == GUARD_LAST);

  // Next-state, counters and registered output decode
  always_comb begin
    state_d   = state_q;
    qual_d    = qual_q;
    vs_miss_d = vs_miss_q;
    guard_d   = guard_q;
    sel_d     = SEL_LOCAL;
    pipe_rst_d = 1'b1;
    hdmi_ok_d  = 1'b0;

    case (state_q)
      BOOT:   if (guard_done) state_d = LOCAL;
      LOCAL: begin
        if (win_done) begin
          // Saturating run length of qualifying windows
          if (win_good && vs_seen) begin
            if (qual_q != QUAL_MAX) qual_d = qual_q + QUAL_W'(1);
          end else begin
            qual_d = '0;
          end
          if ((qual_d == QUAL_MAX) && !force_local) state_d = PRE_H;
        end
      end
      PRE_H:  if (guard_done) state_d = POST_H;
      POST_H: if (guard_done) state_d = HDMI;
      HDMI: begin
        if (force_local) begin
          state_d = PRE_L;
        end else if (win_done) begin
          if (!win_good) begin
            state_d = PRE_L;
          end else if (!vs_seen) begin
            vs_miss_d = vs_miss_q + VS_W'(1);
            if (vs_miss_d == VS_MAX) state_d = PRE_L;
          end else begin
            vs_miss_d = '0;
          end
        end
      end
      PRE_L:  if (guard_done) state_d = POST_L;
      POST_L: if (guard_done) state_d = LOCAL;
      default: state_d = BOOT;
    endcase

    // Every state entry starts its guard and run counters from zero
    if (state_d != state_q) begin
      guard_d   = '0;
      qual_d    = '0;
      vs_miss_d = '0;
    end else if (!guard_done) begin
      guard_d = guard_q + GUARD_W'(1);
    end

    if ((state_d == POST_H) || (state_d == HDMI) || (state_d == PRE_L)) sel_d = SEL_HDMI;
    if ((state_d == LOCAL) || (state_d == HDMI)) pipe_rst_d = 1'b0;
    hdmi_ok_d = (state_d == HDMI);
  end

  always_ff @(posedge clk75 or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      guard_q    <= '0;
      qual_q     <= '0;
      vs_miss_q  <= '0;
      sel_q      <= SEL_LOCAL;
      pipe_rst_q <= 1'b1;
      hdmi_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      qual_q     <= qual_d;
      vs_miss_q  <= vs_miss_d;
      sel_q      <= sel_d;
      pipe_rst_q <= pipe_rst_d;
      hdmi_ok_q  <= hdmi_ok_d;
    end
  end

  assign sel      = sel_q;
  assign pipe_rst = pipe_rst_q;
  assign hdmi_ok  = hdmi_ok_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_hdmi_clk_src_ctrl.sv
// tb_hdmi_clk_src_ctrl: directed bench for hdmi_clk_src_ctrl with a small
// window (1024), guard 16 and edge limits 10..40. Stimulus is generated in
// lock-step with a cycle count since reset release so expected times are exact.
module tb_hdmi_clk_src_ctrl;

  localparam int S_BOOT = 0, S_LOCAL = 1, S_PRE_H = 2, S_POST_H = 3;
  localparam int S_HDMI = 4, S_PRE_L = 5, S_POST_L = 6;

  logic        clk75, rst, tmds_div, vsync, force_local;
  logic        sel, pipe_rst, hdmi_ok;
  logic [15:0] edge_cnt;
  logic [2:0]  state_o;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;           // posedges since reset release
  int sel_low_cnt = 0;   // negedge samples with sel == 0
  int gen_mode = 0;      // 0 idle, 1 periodic, 2 burst per window
  int tmds_per = 64;
  int vs_en = 0;
  int burst[8];

  hdmi_clk_src_ctrl #(
    .WIN_CYC(1024), .MIN_EDGES(10), .MAX_EDGES(40),
    .QUAL_WIN(4), .VS_WIN(2), .GUARD_CYC(16)
  ) dut (
    .clk75(clk75), .rst(rst), .tmds_div(tmds_div), .vsync(vsync),
    .force_local(force_local), .sel(sel), .pipe_rst(pipe_rst),
    .hdmi_ok(hdmi_ok), .edge_cnt(edge_cnt), .state_o(state_o)
  );

  initial begin
    clk75 = 1'b0;
    forever #5 clk75 = ~clk75;
  end

  initial forever begin
    @(posedge clk75);
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk75);
    if (sel === 1'b0) sel_low_cnt = sel_low_cnt + 1;
  end

  // Stimulus generator: tmds_div and vsync as functions of the cycle count
  initial begin
    int ph, idx;
    tmds_div = 1'b0;
    vsync    = 1'b0;
    forever begin
      @(negedge clk75);
      ph = cyc % 1024;
      case (gen_mode)
        1: tmds_div = ((cyc % tmds_per) >= (tmds_per / 2));
        2: begin
          idx = cyc / 1024;
          if (idx > 7) idx = 7;
          tmds_div = (ph >= 100) && (((ph - 100) / 20) < burst[idx]) &&
                     (((ph - 100) % 20) < 10);
        end
        default: tmds_div = 1'b0;
      endcase
      vsync = (vs_en != 0) && (ph >= 500) && (ph < 510);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    int budget = 0;
    while (cyc < n) begin
      @(negedge clk75);
      budget = budget + 1;
      if (budget > 20000) begin
        n_chk = n_chk + 1;
        $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        break;
      end
    end
  endtask

  task automatic start_run();
    rst = 1'b1;
    repeat (3) @(negedge clk75);
    sel_low_cnt = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    force_local = 1'b0;
    repeat (3) @(negedge clk75);
    check("rst_sel", 32'(sel), 1);
    check("rst_pipe_rst", 32'(pipe_rst), 1);
    check("rst_hdmi_ok", 32'(hdmi_ok), 0);
    check("rst_edge_cnt", 32'(edge_cnt), 0);
    check("rst_state", 32'(state_o), S_BOOT);

    // 1. No TMDS activity
    gen_mode = 0; vs_en = 0;
    start_run();
    wait_cyc(15);   check("t1_boot_pipe_rst", 32'(pipe_rst), 1);
                    check("t1_boot_state", 32'(state_o), S_BOOT);
    wait_cyc(16);   check("t1_local_pipe_rst", 32'(pipe_rst), 0);
                    check("t1_local_state", 32'(state_o), S_LOCAL);
    wait_cyc(3073); check("t1_state", 32'(state_o), S_LOCAL);
                    check("t1_edge_cnt", 32'(edge_cnt), 0);
                    check("t1_sel_never_low", 32'(sel_low_cnt), 0);

    // 3. Ghost clock: 4 edges per window
    gen_mode = 1; tmds_per = 256; vs_en = 1;
    start_run();
    wait_cyc(1025); check("t3_edge_cnt_w1", 32'(edge_cnt), 4);
    wait_cyc(5121); check("t3_edge_cnt_w5", 32'(edge_cnt), 4);
                    check("t3_state", 32'(state_o), S_LOCAL);
                    check("t3_sel_never_low", 32'(sel_low_cnt), 0);

    // 4a. 10 qualifies, 9 clears the run, 40 qualifies
    gen_mode = 2; vs_en = 1;
    burst = '{10, 10, 10, 9, 40, 40, 40, 40};
    start_run();
    wait_cyc(1025); check("t4a_edge_cnt_10", 32'(edge_cnt), 10);
    wait_cyc(4097); check("t4a_edge_cnt_9", 32'(edge_cnt), 9);
                    check("t4a_state_w4", 32'(state_o), S_LOCAL);
    wait_cyc(5121); check("t4a_state_w5", 32'(state_o), S_LOCAL);
    wait_cyc(8192); check("t4a_state_pre", 32'(state_o), S_LOCAL);
    wait_cyc(8193); check("t4a_state_w8", 32'(state_o), S_PRE_H);
                    check("t4a_pipe_rst", 32'(pipe_rst), 1);

    // 4b. 40 qualifies, 41 clears the run, 10 qualifies
    burst = '{40, 40, 40, 41, 10, 10, 10, 10};
    start_run();
    wait_cyc(1025); check("t4b_edge_cnt_40", 32'(edge_cnt), 40);
    wait_cyc(4097); check("t4b_edge_cnt_41", 32'(edge_cnt), 41);
                    check("t4b_state_w4", 32'(state_o), S_LOCAL);
    wait_cyc(5121); check("t4b_state_w5", 32'(state_o), S_LOCAL);
    wait_cyc(8192); check("t4b_state_pre", 32'(state_o), S_LOCAL);
    wait_cyc(8193); check("t4b_state_w8", 32'(state_o), S_PRE_H);

    // 2. Valid source: 16 edges per window, vsync each window
    gen_mode = 1; tmds_per = 64; vs_en = 1;
    start_run();
    wait_cyc(4096); check("t2_state_w4", 32'(state_o), S_LOCAL);
                    check("t2_pipe_rst_low", 32'(pipe_rst), 0);
    wait_cyc(4097); check("t2_state_pre_h", 32'(state_o), S_PRE_H);
                    check("t2_pipe_rst_rise", 32'(pipe_rst), 1);
                    check("t2_edge_cnt", 32'(edge_cnt), 16);
    wait_cyc(4112); check("t2_sel_hold", 32'(sel), 1);
    wait_cyc(4113); check("t2_sel_flip", 32'(sel), 0);
                    check("t2_state_post_h", 32'(state_o), S_POST_H);
    wait_cyc(4128); check("t2_pipe_rst_hold", 32'(pipe_rst), 1);
                    check("t2_hdmi_ok_pre", 32'(hdmi_ok), 0);
    wait_cyc(4129); check("t2_pipe_rst_fall", 32'(pipe_rst), 0);
                    check("t2_hdmi_ok", 32'(hdmi_ok), 1);
                    check("t2_state_hdmi", 32'(state_o), S_HDMI);
    vs_en = 0;

    // 5. Loss of vsync while on HDMI
    wait_cyc(6144); check("t5_state_w5", 32'(state_o), S_HDMI);
    wait_cyc(6145); check("t5_state_pre_l", 32'(state_o), S_PRE_L);
                    check("t5_pipe_rst", 32'(pipe_rst), 1);
                    check("t5_sel_still_hdmi", 32'(sel), 0);
    wait_cyc(6160); check("t5_sel_hold", 32'(sel), 0);
    wait_cyc(6161); check("t5_sel_flip", 32'(sel), 1);
                    check("t5_state_post_l", 32'(state_o), S_POST_L);
    wait_cyc(6176); check("t5_pipe_rst_hold", 32'(pipe_rst), 1);
    wait_cyc(6177); check("t5_pipe_rst_fall", 32'(pipe_rst), 0);
                    check("t5_state_local", 32'(state_o), S_LOCAL);
    vs_en = 1;
    wait_cyc(10273); check("t5_requal_hdmi", 32'(state_o), S_HDMI);
    wait_cyc(10300); check("t5_before_force", 32'(state_o), S_HDMI);
    force_local = 1'b1;
    wait_cyc(10301); check("t5_force_pre_l", 32'(state_o), S_PRE_L);
    wait_cyc(10333); check("t5_force_local", 32'(state_o), S_LOCAL);
    wait_cyc(14337); check("t5_force_holds", 32'(state_o), S_LOCAL);
                     check("t5_force_sel", 32'(sel), 1);
    force_local = 1'b0;

    // 6. Reset during the PRE_H guard, then during POST_H
    start_run();
    wait_cyc(4100); check("t6_state_pre_h", 32'(state_o), S_PRE_H);
    rst = 1'b1;
    #1;
    check("t6_rst_sel", 32'(sel), 1);
    check("t6_rst_pipe_rst", 32'(pipe_rst), 1);
    check("t6_rst_state", 32'(state_o), S_BOOT);
    check("t6_rst_edge_cnt", 32'(edge_cnt), 0);
    start_run();
    wait_cyc(3073); check("t6_requal_w3", 32'(state_o), S_LOCAL);
    wait_cyc(4097); check("t6_requal_w4", 32'(state_o), S_PRE_H);
    wait_cyc(4120); check("t6_post_h_sel", 32'(sel), 0);
    rst = 1'b1;
    #1;
    check("t6_rst2_sel", 32'(sel), 1);
    check("t6_rst2_pipe_rst", 32'(pipe_rst), 1);
    check("t6_rst2_state", 32'(state_o), S_BOOT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
